// File: rtl/vc_uio_bank_if.sv
// vc_uio_bank_if: core-side bus of the bidirectional pad bank.
//   master (core): drives core_out/core_oe/filt_len/rise_en/fall_en/
//                  irq_mask/irq_ack; receives core_in/irq_pend/irq.
//   slave  (bank): the opposite directions.
interface vc_uio_bank_if #(
    parameter int WIDTH     = 8,
    parameter int FILT_BITS = 4
);
    logic [WIDTH-1:0]     core_out;
    logic [WIDTH-1:0]     core_oe;
    logic [WIDTH-1:0]     core_in;
    logic [FILT_BITS-1:0] filt_len;
    logic [WIDTH-1:0]     rise_en;
    logic [WIDTH-1:0]     fall_en;
    logic [WIDTH-1:0]     irq_mask;
    logic [WIDTH-1:0]     irq_ack;
    logic [WIDTH-1:0]     irq_pend;
    logic                 irq;

    modport master (
        output core_out, core_oe, filt_len, rise_en, fall_en, irq_mask, irq_ack,
        input  core_in, irq_pend, irq
    );

    modport slave (
        input  core_out, core_oe, filt_len, rise_en, fall_en, irq_mask, irq_ack,
        output core_in, irq_pend, irq
    );
endinterface

// File: rtl/vc_uio_bank.sv
// vc_uio_bank: parametrised bidirectional pad bank.
//   Registered out/oe, SYNC_STAGES-deep input synchroniser, per-pin glitch
//   filter (filt_len stable cycles, 0 treated as 1), per-pin edge-detect
//   pending bits (write-one-to-clear, set wins) and one masked, registered irq.
// Ports:
//   clk, reset  - bank clock, synchronous active-high reset
//   bus         - vc_uio_bank_if.slave (core_out/oe/in, filt_len, edge enables,
//                 irq_mask/ack/pend, irq)
//   pad_io      - physical pins
//   od_en       - per-pin open-drain select (only with VC_UIO_OPEN_DRAIN_EN)
// Optional feature macro: VC_UIO_OPEN_DRAIN_EN.
// SYNC_STAGES legal range is 2..4.

// Per-pin slice: output regs, synchroniser, filter, edge detect.
module vc_uio_pin #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_BITS   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 core_out,
    input  logic                 core_oe,
    input  logic                 pad_i,
    input  logic [FILT_BITS-1:0] filt_len,
    input  logic                 rise_en,
    input  logic                 fall_en,
    input  logic                 irq_ack,
    output logic                 out_q,
    output logic                 oe_q,
    output logic                 filt_q,
    output logic                 pend_q
);
    logic                   out_d, oe_d, filt_d, pend_d, prev_d, prev_q;
    logic [SYNC_STAGES-1:0] sync_d, sync_q;
    logic [FILT_BITS-1:0]   cnt_d, cnt_q, len_m1;
    logic                   sync, rise, fall;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        out_d  = core_out;
        oe_d   = core_oe;
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
        // filt_len of 0 behaves like 1 (accept on first mismatch cycle)
        len_m1 = (filt_len == '0) ? '0 : filt_len - FILT_BITS'(1);
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (sync == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q >= len_m1) begin
            // >= so that shrinking filt_len mid-count accepts on the next mismatch
            filt_d = sync;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + FILT_BITS'(1);
        end
        prev_d = filt_q;
        rise   = filt_q & ~prev_q & rise_en;
        fall   = ~filt_q & prev_q & fall_en;
        // set after clear: an edge coinciding with an ack keeps the bit
        pend_d = (pend_q & ~irq_ack) | rise | fall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= 1'b0;
            oe_q   <= 1'b0;
            sync_q <= '0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            oe_q   <= oe_d;
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
            prev_q <= prev_d;
            pend_q <= pend_d;
        end
    end
endmodule

module vc_uio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_BITS   = 4
) (
    input  logic             clk,
    input  logic             reset,
    vc_uio_bank_if.slave     bus,
`ifdef VC_UIO_OPEN_DRAIN_EN
    input  logic [WIDTH-1:0] od_en,
`endif
    inout  wire  [WIDTH-1:0] pad_io
);
    logic [WIDTH-1:0] out_q, oe_q, filt_q, pend_q;
    logic             irq_d, irq_q;

`ifdef VC_UIO_OPEN_DRAIN_EN
    logic [WIDTH-1:0] od_d, od_q;

    always_comb od_d = od_en;

    always_ff @(posedge clk) begin
        if (reset) od_q <= '0;
        else       od_q <= od_d;
    end
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        vc_uio_pin #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_BITS   (FILT_BITS)
        ) u_pin (
            .clk      (clk),
            .reset    (reset),
            .core_out (bus.core_out[i]),
            .core_oe  (bus.core_oe[i]),
            .pad_i    (pad_io[i]),
            .filt_len (bus.filt_len),
            .rise_en  (bus.rise_en[i]),
            .fall_en  (bus.fall_en[i]),
            .irq_ack  (bus.irq_ack[i]),
            .out_q    (out_q[i]),
            .oe_q     (oe_q[i]),
            .filt_q   (filt_q[i]),
            .pend_q   (pend_q[i])
        );

`ifdef VC_UIO_OPEN_DRAIN_EN
        // open-drain pins only ever pull low; high comes from the board
        assign pad_io[i] = od_q[i] ? ((oe_q[i] & ~out_q[i]) ? 1'b0 : 1'bz)
                                   : (oe_q[i] ? out_q[i] : 1'bz);
`else
        assign pad_io[i] = oe_q[i] ? out_q[i] : 1'bz;
`endif
    end

    always_comb irq_d = |(pend_q & bus.irq_mask);

    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign bus.core_in  = filt_q;
    assign bus.irq_pend = pend_q;
    assign bus.irq      = irq_q;
endmodule

// File: doc/vc_uio_bank.md
Name: vc_uio_bank

Overview:
Parametrised bidirectional pad bank that sits between the CPU core's uio_out/uio_oe/uio_in bus and the board's inout pins. It replaces bare per-pin tristate assigns with:
- registered output and output-enable;
- multi-stage input synchronisers;
- a per-pin glitch filter;
- per-pin edge-detect interrupt pending bits feeding one maskable interrupt line to the core.

Parameters:
WIDTH, 8, number of pins in the bank.
SYNC_STAGES, 2, input synchroniser depth (legal 2..4).
FILT_BITS, 4, width of the per-pin filter counter and of filt_len.

Ports:
clk  input  1  bank clock (core clock domain).
reset  input  1  synchronous, active-high reset.
core_out  input  WIDTH  value to drive per pin.
core_oe  input  WIDTH  per-pin output enable (1 = drive, 0 = hi-Z).
core_in  output  WIDTH  synchronised, filtered pin values.
pad_io  inout  WIDTH  physical pins.
filt_len  input  FILT_BITS  required stable cycles before core_in changes (0 treated as 1).
rise_en  input  WIDTH  per-pin enable: rising edge sets pending.
fall_en  input  WIDTH  per-pin enable: falling edge sets pending.
irq_mask  input  WIDTH  per-pin interrupt mask (1 = enabled).
irq_ack  input  WIDTH  write-one-to-clear for pending bits, sampled every cycle.
irq_pend  output  WIDTH  pending edge bits.
irq  output  1  OR of (irq_pend & irq_mask), registered.

Behaviour:
- Clocking: all state is on the rising edge of clk. reset is synchronous and active-high and overrides everything else in the same cycle.
- Reset values:
  - out_q = 0, oe_q = 0, so every pin is hi-Z.
  - All synchroniser stages = 0; filtered = 0; all filter counters = 0.
  - core_in = 0, irq_pend = 0, irq = 0.
- Output path:
  - out_q <= core_out and oe_q <= core_oe every cycle.
  - pad_io[i] = oe_q[i] ? out_q[i] : Z.
  - Latency core_out/core_oe -> pin: 1 cycle.
- Input path:
  - pad_io passes through SYNC_STAGES flops; the last stage is sync[i].
  - Pins that are being driven are still sampled, so the driven value is read back.
- Filter, per pin, with L = max(filt_len, 1):
  - If sync == filtered: cnt <= 0.
  - Else if cnt == L-1: filtered <= sync, cnt <= 0.
  - Else: cnt <= cnt + 1.
  - A new level must be present at sync for L consecutive cycles before it is accepted. Any bounce back resets the count.
  - Changing filt_len mid-count takes effect on the next compare. If cnt is already >= L-1, the update happens on the next mismatch cycle.
  - core_in = filtered.
  - Latency pad -> core_in with L = 1: SYNC_STAGES + 1 cycles.
- Edge detect, per pin, using prev = filtered delayed 1 cycle:
  - rise = filtered & ~prev & rise_en.
  - fall = ~filtered & prev & fall_en.
  - irq_pend[i] <= (irq_pend[i] & ~irq_ack[i]) | rise | fall.
  - If an edge and an ack coincide on the same pin, the set wins.
  - irq_pend updates regardless of irq_mask.
- Interrupt: irq <= |(irq_pend & irq_mask), i.e. 1 cycle after irq_pend.
- Reset asserted mid-filter or mid-pending: all state returns to reset values. Edges present at reset release are not reported, because prev and filtered both start at 0.

Optional Feature:
VC_UIO_OPEN_DRAIN_EN.
- When defined:
  - Adds input port od_en[WIDTH], registered into od_q with 1-cycle latency and reset value 0.
  - For a pin with od_q = 1: pad_io = (oe_q & ~out_q) ? 0 : Z. It never drives 1.
  - For a pin with od_q = 0: push-pull behaviour as above.
- When undefined: the od_en port does not exist and all pins are push-pull.

Test Plan:
1. Reset with pad pull-ups, then release -> pad_io all Z, core_in = 0x00 until the sync/filter latency passes, then 0xFF. irq_pend = 0 and irq = 0 throughout.
2. core_oe = 0x0F, core_out = 0xA5 -> one cycle later pad_io[3:0] = 4'h5 and pad_io[7:4] = Z. With filt_len = 1, core_in[3:0] = 4'h5 after 3 more cycles.
3. filt_len = 4, pin 0 external 0->1 held 3 cycles then back to 0 -> core_in[0] stays 0. The same pulse held 4 cycles -> core_in[0] rises exactly 4 cycles after sync[0] rises.
4. rise_en[2] = 1, irq_mask[2] = 1, pin 2 rises -> irq_pend[2] = 1 the cycle after core_in[2] rises, and irq = 1 one cycle later. irq_ack[2] pulse -> both clear. Ack coinciding with a new edge -> irq_pend[2] stays 1.
5. fall_en = 0, rise_en = 0, pin toggles -> irq_pend never sets. irq_mask = 0 with a pending bit -> irq = 0 and irq_pend stays 1.
6. WIDTH = 16, SYNC_STAGES = 3, with VC_UIO_OPEN_DRAIN_EN, od_en[9] = 1, oe = 1, out[9] = 1 -> pad_io[9] = Z. out[9] = 0 -> pad_io[9] = 0.
